// File: rtl/reg_16x4_search.sv
// Reverse lookup for the fixed 16x4 constant table.
// A captured key is compared against one table entry per clock. The block
// reports the lowest matching address and the number of matching entries.
// With STOP_ON_FIRST set, the scan ends at the first hit.
module reg_16x4_search #(
   parameter bit STOP_ON_FIRST = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start,
   input  logic [3:0] Key,
   output logic       Busy,
   output logic       Done,
   output logic       Found,
   output logic [3:0] MatchAddr,
   output logic [4:0] Count
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Same contents as the forward table; must be kept in step with it.
   function automatic logic [3:0] f_table(input logic [3:0] addr);
      logic [3:0] val;
      case (addr)
         4'h0: val = 4'hC;
         4'h1: val = 4'h2;
         4'h2: val = 4'h9;
         4'h3: val = 4'hA;
         4'h4: val = 4'h7;
         4'h5: val = 4'h1;
         4'h6: val = 4'hC;
         4'h7: val = 4'h0;
         4'h8: val = 4'hF;
         4'h9: val = 4'h1;
         4'hA: val = 4'h3;
         4'hB: val = 4'hD;
         4'hC: val = 4'h8;
         4'hD: val = 4'hE;
         4'hE: val = 4'hA;
         default: val = 4'h6;
      endcase
      return val;
   endfunction

   state_t     r_state;
   logic [3:0] r_ptr;
   logic [3:0] r_key;
   logic       r_done;
   logic       r_found;
   logic [3:0] r_addr;
   logic [4:0] r_count;

   state_t     w_state_nx;
   logic [3:0] w_ptr_nx;
   logic [3:0] w_key_nx;
   logic       w_done_nx;
   logic       w_found_nx;
   logic [3:0] w_addr_nx;
   logic [4:0] w_count_nx;
   logic       w_hit;
   logic       w_last;

   // Entry under the pointer versus the latched key; only meaningful in SCAN.
   assign w_hit  = (f_table(r_ptr) == r_key);
   // The scan ends after entry 15, or at the first hit in early-exit mode.
   assign w_last = (r_ptr == 4'hF) || (STOP_ON_FIRST && w_hit);

   // Next-state and next-result logic; all registers hold unless changed here.
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_key_nx   = r_key;
      w_done_nx  = 1'b0;
      w_found_nx = r_found;
      w_addr_nx  = r_addr;
      w_count_nx = r_count;
      case (r_state)
         IDLE: begin
            // Results from the previous search are held until a new Start.
            if (Start) begin
               w_key_nx   = Key;
               w_ptr_nx   = 4'h0;
               w_found_nx = 1'b0;
               w_addr_nx  = 4'h0;
               w_count_nx = 5'd0;
               w_state_nx = SCAN;
            end
         end
         SCAN: begin
            // Start and Key are deliberately not looked at while scanning.
            if (w_hit) begin
               w_count_nx = r_count + 5'd1;
               if (!r_found) begin
                  w_found_nx = 1'b1;
                  w_addr_nx  = r_ptr;
               end
            end
            if (w_last) begin
               w_done_nx  = 1'b1;
               w_ptr_nx   = 4'h0;
               w_state_nx = IDLE;
            end else begin
               w_ptr_nx = r_ptr + 4'd1;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // State and result registers; reset wins over everything, including mid-scan.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_ptr   <= 4'h0;
         r_key   <= 4'h0;
         r_done  <= 1'b0;
         r_found <= 1'b0;
         r_addr  <= 4'h0;
         r_count <= 5'd0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_key   <= w_key_nx;
         r_done  <= w_done_nx;
         r_found <= w_found_nx;
         r_addr  <= w_addr_nx;
         r_count <= w_count_nx;
      end
   end

   assign Busy      = (r_state == SCAN);
   assign Done      = r_done;
   assign Found     = r_found;
   assign MatchAddr = r_addr;
   assign Count     = r_count;

endmodule

// File: tb/tb_reg_16x4_search.sv
// Bench for reg_16x4_search: one instance scanning all entries and one in
// early-exit mode, driven by the same inputs and checked cycle by cycle
// against a table-based expectation of count, first address and latency.
module tb_reg_16x4_search;

   logic       CLK = 1'b0;
   logic       RST;
   logic       Start;
   logic [3:0] Key;

   logic       busy0, done0, found0;
   logic [3:0] addr0;
   logic [4:0] cnt0;
   logic       busy1, done1, found1;
   logic [3:0] addr1;
   logic [4:0] cnt1;

   int n_total = 0;
   int n_bad   = 0;

   // expected held results for each instance
   logic [31:0] e0_f, e0_a, e0_c, e1_f, e1_a, e1_c;

   logic [3:0] TBL [16];

   always #5 CLK = ~CLK;

   reg_16x4_search #(.STOP_ON_FIRST(1'b0)) u_full (
      .CLK(CLK), .RST(RST), .Start(Start), .Key(Key),
      .Busy(busy0), .Done(done0), .Found(found0), .MatchAddr(addr0), .Count(cnt0)
   );

   reg_16x4_search #(.STOP_ON_FIRST(1'b1)) u_stop (
      .CLK(CLK), .RST(RST), .Start(Start), .Key(Key),
      .Busy(busy1), .Done(done1), .Found(found1), .MatchAddr(addr1), .Count(cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_res0(input string tag);
      chk({tag, " found0"}, 32'(found0), e0_f);
      chk({tag, " addr0"},  32'(addr0),  e0_a);
      chk({tag, " cnt0"},   32'(cnt0),   e0_c);
   endtask

   task automatic chk_res1(input string tag);
      chk({tag, " found1"}, 32'(found1), e1_f);
      chk({tag, " addr1"},  32'(addr1),  e1_a);
      chk({tag, " cnt1"},   32'(cnt1),   e1_c);
   endtask

   // Idle cycles with Start low: nothing runs, results hold.
   task automatic idle_check(input int n);
      Start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         chk("idle busy0", 32'(busy0), 32'd0);
         chk("idle busy1", 32'(busy1), 32'd0);
         chk("idle done0", 32'(done0), 32'd0);
         chk("idle done1", 32'(done1), 32'd0);
         chk_res0("idle");
         chk_res1("idle");
      end
   endtask

   // One search. Called at #1 after an edge; Start is raised for the next edge.
   // mid_c (1..16) re-pulses Start with mid_key before scan edge mid_c.
   task automatic run_search(input logic [3:0] k, input int mid_c, input logic [3:0] mid_key);
      int cnt, first, s_lat, mc;
      cnt   = 0;
      first = -1;
      for (int a = 0; a < 16; a++) begin
         if (TBL[a] == k) begin
            cnt++;
            if (first < 0) first = a;
         end
      end
      e0_f  = (cnt > 0) ? 32'd1 : 32'd0;
      e0_a  = (cnt > 0) ? 32'(first) : 32'd0;
      e0_c  = 32'(cnt);
      e1_f  = e0_f;
      e1_a  = e0_a;
      e1_c  = (cnt > 0) ? 32'd1 : 32'd0;
      s_lat = (cnt > 0) ? first + 1 : 16;
      // A re-pulse after the early-exit instance finished would be a real start there.
      mc = (mid_c >= 1 && mid_c <= s_lat) ? mid_c : 0;

      Start = 1'b1;
      Key   = k;
      @(posedge CLK); #1;
      Start = 1'b0;
      Key   = 4'($urandom);
      chk("start busy0", 32'(busy0), 32'd1);
      chk("start busy1", 32'(busy1), 32'd1);
      chk("start done0", 32'(done0), 32'd0);
      chk("start done1", 32'(done1), 32'd0);
      chk("clr found0", 32'(found0), 32'd0);
      chk("clr addr0",  32'(addr0),  32'd0);
      chk("clr cnt0",   32'(cnt0),   32'd0);
      chk("clr cnt1",   32'(cnt1),   32'd0);

      for (int e = 1; e <= 16; e++) begin
         if (e == mc) begin
            Start = 1'b1;
            Key   = mid_key;
         end
         @(posedge CLK); #1;
         Start = 1'b0;
         Key   = 4'($urandom);
         chk("scan done0", 32'(done0), 32'(e == 16));
         chk("scan busy0", 32'(busy0), 32'(e < 16));
         chk("scan done1", 32'(done1), 32'(e == s_lat));
         chk("scan busy1", 32'(busy1), 32'(e < s_lat));
         if (e >= s_lat) chk_res1("res");
         if (e == 16) chk_res0("res");
      end
   endtask

   initial begin
      logic [3:0] rk, mk;
      int         mc;
      TBL = '{4'hC, 4'h2, 4'h9, 4'hA, 4'h7, 4'h1, 4'hC, 4'h0,
              4'hF, 4'h1, 4'h3, 4'hD, 4'h8, 4'hE, 4'hA, 4'h6};
      RST   = 1'b1;
      Start = 1'b0;
      Key   = 4'h0;
      e0_f = 0; e0_a = 0; e0_c = 0; e1_f = 0; e1_a = 0; e1_c = 0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst busy0", 32'(busy0), 32'd0);
      chk("rst done0", 32'(done0), 32'd0);
      chk_res0("rst");
      chk("rst busy1", 32'(busy1), 32'd0);
      chk_res1("rst");
      RST = 1'b0;
      idle_check(3);

      // directed cases
      run_search(4'hC, 0, 4'h0);
      idle_check(1);
      run_search(4'h6, 0, 4'h0);
      run_search(4'h4, 0, 4'h0);   // issued in the Done cycle
      idle_check(2);
      run_search(4'h1, 0, 4'h0);
      run_search(4'hA, 0, 4'h0);
      idle_check(1);
      run_search(4'hA, 3, 4'h2);   // second Start mid-scan is ignored
      idle_check(1);

      // reset in the middle of a scan
      Start = 1'b1;
      Key   = 4'hC;
      @(posedge CLK); #1;
      Start = 1'b0;
      repeat (7) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      e0_f = 0; e0_a = 0; e0_c = 0; e1_f = 0; e1_a = 0; e1_c = 0;
      chk("mrst busy0", 32'(busy0), 32'd0);
      chk("mrst done0", 32'(done0), 32'd0);
      chk_res0("mrst");
      chk("mrst busy1", 32'(busy1), 32'd0);
      chk_res1("mrst");
      idle_check(1);
      run_search(4'h0, 0, 4'h0);
      idle_check(1);

      // random searches, random back-to-back and mid-scan Start pulses
      repeat (30) begin
         rk = 4'($urandom);
         mk = 4'($urandom);
         mc = int'($urandom_range(0, 16));
         run_search(rk, mc, mk);
         if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 2)));
      end
      idle_check(1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
